// File: rtl/seq_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// seq_magnitude_comparator
//
// Multi-cycle magnitude comparator. Two WIDTH-bit operands are latched on an
// accepted start and compared MSB-first, CHUNK bits per clock, in either
// signed (two's-complement) or unsigned mode. The walk stops on the first
// chunk that differs, so done arrives after k edges (1 <= k <= NCHUNK).
//
// Ports
//   clk        in   1      clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   start      in   1      request; accepted only when busy==0
//   a          in   WIDTH  operand A, sampled on the accepting edge
//   b          in   WIDTH  operand B, sampled on the accepting edge
//   is_signed  in   1      1 = two's-complement compare, 0 = unsigned
//   busy       out  1      comparison in progress
//   done       out  1      result valid; held until the next accepted start
//   lt         out  1      A < B  (valid while done)
//   eq         out  1      A == B (valid while done)
//   gt         out  1      A > B  (valid while done)
// ---------------------------------------------------------------------------
module seq_magnitude_comparator #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

    // Reject parameter combinations that cannot be split into whole chunks.
    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("seq_magnitude_comparator: WIDTH must be >= 2");
        end
        if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
            $error("seq_magnitude_comparator: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                          state, state_next;
    logic [WIDTH-1:0]                a_reg, a_next;
    logic [WIDTH-1:0]                b_reg, b_next;
    logic                            signed_reg, signed_next;
    logic [IDXW-1:0]                 idx, idx_next;
    logic                            busy_next, done_next;
    logic                            lt_next, eq_next, gt_next;

    // Viewing the latched operands as arrays of chunks lets the walk select
    // the current slice with a plain index instead of a multiplied offset.
    logic [NCHUNK-1:0][CHUNK-1:0]    a_chunks, b_chunks;
    logic [CHUNK-1:0]                chunk_a, chunk_b;
    logic                            sign_split;

    assign a_chunks = a_reg;
    assign b_chunks = b_reg;
    assign chunk_a  = a_chunks[idx];
    assign chunk_b  = b_chunks[idx];

    // In signed mode a sign-bit difference decides the result outright: the
    // negative operand is the smaller one, whatever the rest of the top chunk.
    assign sign_split = signed_reg && (idx == IDX_TOP) &&
                        (a_reg[WIDTH-1] != b_reg[WIDTH-1]);

    // Next-state and next-output logic. Every register holds its value by
    // default; a start from IDLE or DONE reloads the operands and clears the
    // result, and each BUSY cycle either resolves the compare or steps down
    // one chunk.
    always_comb begin
        state_next  = state;
        a_next      = a_reg;
        b_next      = b_reg;
        signed_next = signed_reg;
        idx_next    = idx;
        busy_next   = busy;
        done_next   = done;
        lt_next     = lt;
        eq_next     = eq;
        gt_next     = gt;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    a_next      = a;
                    b_next      = b;
                    signed_next = is_signed;
                    idx_next    = IDX_TOP;
                    busy_next   = 1'b1;
                    done_next   = 1'b0;
                    lt_next     = 1'b0;
                    eq_next     = 1'b0;
                    gt_next     = 1'b0;
                    state_next  = BUSY;
                end
            end

            BUSY: begin
                if (sign_split) begin
                    lt_next    = a_reg[WIDTH-1];
                    gt_next    = ~a_reg[WIDTH-1];
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = DONE;
                end else if (chunk_a != chunk_b) begin
                    lt_next    = (chunk_a < chunk_b);
                    gt_next    = (chunk_a > chunk_b);
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = DONE;
                end else if (idx == '0) begin
                    eq_next    = 1'b1;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = DONE;
                end else begin
                    idx_next   = idx - IDXW'(1);
                end
            end

            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                done_next  = 1'b0;
                lt_next    = 1'b0;
                eq_next    = 1'b0;
                gt_next    = 1'b0;
            end
        endcase
    end

    // State, operand and result registers. Reset abandons any compare in
    // flight; all outputs come straight from these flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            signed_reg <= 1'b0;
            idx        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            lt         <= 1'b0;
            eq         <= 1'b0;
            gt         <= 1'b0;
        end else begin
            state      <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            signed_reg <= signed_next;
            idx        <= idx_next;
            busy       <= busy_next;
            done       <= done_next;
            lt         <= lt_next;
            eq         <= eq_next;
            gt         <= gt_next;
        end
    end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// tb_seq_magnitude_comparator
//
// Drives directed and randomized compares into seq_magnitude_comparator and
// checks results, latency and handshake against an arithmetic reference.
// ---------------------------------------------------------------------------
module tb_seq_magnitude_comparator;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             busy;
    logic             done;
    logic             lt;
    logic             eq;
    logic             gt;

    int checkCount;
    int passCount;

    seq_magnitude_comparator #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .busy      (busy),
        .done      (done),
        .lt        (lt),
        .eq        (eq),
        .gt        (gt)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference model: the relation comes from plain signed/unsigned
    // arithmetic, and the chunk count from the position of the highest
    // differing bit (all chunks when the operands are equal).
    task automatic refCompare(input logic [31:0] va, input logic [31:0] vb,
                              input logic sg, output logic elt, output logic eeq,
                              output logic egt, output int k);
        logic [31:0] diff;
        int          top;
        if (sg) begin
            elt = $signed(va) < $signed(vb);
            egt = $signed(va) > $signed(vb);
        end else begin
            elt = va < vb;
            egt = va > vb;
        end
        eeq  = (va == vb);
        diff = va ^ vb;
        top  = -1;
        for (int i = 0; i < WIDTH; i++) begin
            if (diff[i]) top = i;
        end
        k = (top < 0) ? NCHUNK : NCHUNK - (top / CHUNK);
    endtask

    // Waits for done with a bounded budget; cycles already spent since the
    // accepting edge are passed in so latency is measured from that edge.
    task automatic waitDone(inout int cycles);
        while (!done && cycles < NCHUNK + 4) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    // One full compare: request, check acceptance, wait, check result and
    // latency. Inputs are scrambled after the accepting edge.
    task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb,
                                 input logic sg, input string tag);
        logic elt, eeq, egt;
        int   k;
        int   cycles;
        refCompare(va, vb, sg, elt, eeq, egt, k);
        @(negedge clk);
        a         = va;
        b         = vb;
        is_signed = sg;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        a         = $urandom;
        b         = $urandom;
        is_signed = 1'($urandom_range(0, 1));
        checkOutput({tag, "_accept"}, {27'd0, busy, done, lt, eq, gt}, 32'b10000);
        cycles = 0;
        waitDone(cycles);
        checkOutput({tag, "_latency"}, cycles, k);
        checkOutput({tag, "_result"}, {27'd0, busy, done, lt, eq, gt},
                    {27'd0, 1'b0, 1'b1, elt, eeq, egt});
    endtask

    initial begin
        int          cycles;
        int          badHold;
        logic [31:0] ra, rb;
        logic        rs;

        checkCount = 0;
        passCount  = 0;
        reset      = 1'b1;
        start      = 1'b0;
        a          = '0;
        b          = '0;
        is_signed  = 1'b0;

        #1;
        checkOutput("reset_state", {27'd0, busy, done, lt, eq, gt}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Equal operands walk every chunk.
        applyStimulus(32'h12345678, 32'h12345678, 1'b0, "equal");

        // Sign bit decides in one cycle, in opposite directions per mode.
        applyStimulus(32'h80000000, 32'h00000001, 1'b1, "msb_signed");
        applyStimulus(32'h80000000, 32'h00000001, 1'b0, "msb_unsigned");

        // Late differences.
        applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, "neg_lsb");
        applyStimulus(32'h00000010, 32'h00000001, 1'b0, "chunk1");

        // A start pulse while busy must be ignored entirely.
        @(negedge clk);
        a = 32'd5; b = 32'd9; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        a = 32'd9; b = 32'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cycles = 1;
        waitDone(cycles);
        checkOutput("ignore_latency", cycles, NCHUNK);
        checkOutput("ignore_result", {27'd0, busy, done, lt, eq, gt}, 32'b01100);
        badHold = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if ({busy, done, lt, eq, gt} !== 5'b01100) badHold++;
        end
        checkOutput("ignore_hold", badHold, 0);

        // Reset three cycles into a long compare clears everything at once.
        @(negedge clk);
        a = 32'h12345678; b = 32'h12345678; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset", {27'd0, busy, done, lt, eq, gt}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(32'h00000003, 32'h00000007, 1'b0, "after_reset");

        // Back-to-back from DONE is exercised by every consecutive call;
        // this one also flips the relation.
        applyStimulus(32'h7FFFFFFF, 32'h80000000, 1'b1, "b2b_signed");

        // Randomized compares, biased toward long walks and sign cases.
        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = ra;
                2:       rb = ra ^ (32'd1 << $urandom_range(0, 31));
                default: rb = {ra[31:12], 12'($urandom)};
            endcase
            rs = 1'($urandom_range(0, 1));
            applyStimulus(ra, rb, rs, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
